// File: rtl/ctl_master.sv
// ctl_master: initiator for the semaphore control bus.
//
// Commands (write or read) are queued in a DEPTH-entry FIFO through a
// valid/ready port and replayed one at a time on the ctl_* bus. Each command
// occupies one ISSUE cycle, where the strobe is high, followed by one GAP
// cycle, where the bus is idle. For a read, ctl_rddata is captured at the end
// of the GAP cycle and returned through a one-cycle rsp_valid pulse.
//
// Optional feature: define CTL_MASTER_AUTOBOOT_EN to replay a fixed
// six-write boot sequence after every reset, before any host command is
// accepted. The order is addr 4..7 <= BOOT_RAM0..3, addr 1 <= BOOT_DIV,
// addr 0 <= 1. When the macro is undefined, boot_done is tied high.
//
// Ports:
//   clk, clrn     clock (rising edge); asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_data   command input port
//   rsp_valid, rsp_data    read response (one-cycle pulse; data held)
//   busy                   FSM active or commands still queued
//   boot_done              boot sequence complete
//   ctl_wr, ctl_rd, ctl_addr, ctl_wrdata, ctl_rddata   control bus
//   fsm_state              current FSM state (debug)
//
// Handshake: a command transfers at a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on registered state and
// never on cmd_valid. rsp_valid has no backpressure.
module ctl_master #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 3,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BOOT_RAM0 = 32'h0A463214,
  parameter logic [31:0] BOOT_RAM1 = 32'h0A1E281E,
  parameter logic [31:0] BOOT_RAM2 = 32'h0A1E0A64,
  parameter logic [31:0] BOOT_RAM3 = 32'h0A3C5032,
  parameter logic [31:0] BOOT_DIV  = 32'h00000000
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              boot_done,
  output logic              ctl_wr,
  output logic              ctl_rd,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wrdata,
  input  logic [DATA_W-1:0] ctl_rddata,
  output logic [1:0]        fsm_state
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMD_W = 1 + ADDR_W + DATA_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_BOOT  = 2'd3
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------- FIFO
  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop;
  logic             fifo_empty;

  assign fifo_empty = (count == '0);
  assign push       = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_wr, cmd_addr, cmd_data};
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- boot
  function automatic logic [CMD_W-1:0] boot_entry(input logic [2:0] idx);
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    case (idx)
      3'd0:    begin a = ADDR_W'(4); d = DATA_W'(BOOT_RAM0); end
      3'd1:    begin a = ADDR_W'(5); d = DATA_W'(BOOT_RAM1); end
      3'd2:    begin a = ADDR_W'(6); d = DATA_W'(BOOT_RAM2); end
      3'd3:    begin a = ADDR_W'(7); d = DATA_W'(BOOT_RAM3); end
      3'd4:    begin a = ADDR_W'(1); d = DATA_W'(BOOT_DIV);  end
      default: begin a = ADDR_W'(0); d = DATA_W'(1);         end
    endcase
    return {1'b1, a, d};
  endfunction

  logic             booting;    // boot writes still outstanding
  logic             boot_last;  // all six boot writes have been loaded
  logic             load_boot;  // load the next boot write into the command register
  logic [CMD_W-1:0] boot_cmd;

`ifdef CTL_MASTER_AUTOBOOT_EN
  localparam state_t RESET_STATE = S_BOOT;

  logic [2:0] boot_idx;
  logic       boot_done_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      boot_idx    <= '0;
      boot_done_q <= 1'b0;
    end else begin
      if (load_boot) boot_idx <= boot_idx + 3'd1;
      if (state == S_GAP && booting && boot_last) boot_done_q <= 1'b1;
    end
  end

  assign booting   = !boot_done_q;
  assign boot_last = (boot_idx == 3'd6);
  assign boot_cmd  = boot_entry(boot_idx);
  assign boot_done = boot_done_q;
`else
  localparam state_t RESET_STATE = S_IDLE;

  assign booting   = 1'b0;
  assign boot_last = 1'b1;
  assign boot_cmd  = '0;
  assign boot_done = 1'b1;
`endif

  // Host commands are held off until the boot sequence has finished.
  assign cmd_ready = (count != FULL_CNT) && boot_done;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= RESET_STATE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_boot  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_next = S_ISSUE;
          pop        = 1'b1;
        end
      end
      S_ISSUE: state_next = S_GAP;
      S_GAP: begin
        if (booting) begin
          if (boot_last) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_ISSUE;
            load_boot  = 1'b1;
          end
        end else if (!fifo_empty) begin
          state_next = S_ISSUE;
          pop        = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_BOOT: begin
        state_next = S_ISSUE;
        load_boot  = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The command register holds the transaction being replayed.
  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cur_wr   <= 1'b0;
      cur_addr <= '0;
      cur_data <= '0;
    end else if (load_boot) begin
      {cur_wr, cur_addr, cur_data} <= boot_cmd;
    end else if (pop) begin
      {cur_wr, cur_addr, cur_data} <= mem[rd_ptr];
    end
  end

  // The slave presents read data during GAP; sample it at the end of GAP.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == S_GAP && !cur_wr) begin
        rsp_valid <= 1'b1;
        rsp_data  <= ctl_rddata;
      end
    end
  end

  // Outputs: the bus is driven only during ISSUE and held at zero otherwise.
  always_comb begin
    ctl_wr     = 1'b0;
    ctl_rd     = 1'b0;
    ctl_addr   = '0;
    ctl_wrdata = '0;
    if (state == S_ISSUE) begin
      ctl_wr   = cur_wr;
      ctl_rd   = !cur_wr;
      ctl_addr = cur_addr;
      if (cur_wr) ctl_wrdata = cur_data;
    end
  end

  assign busy      = (state == S_ISSUE) || (state == S_GAP) || !fifo_empty;
  assign fsm_state = state;

endmodule

// File: tb/tb_ctl_master.sv
// Testbench for ctl_master. A reference queue of expected bus transactions
// is filled when each command is accepted. A bus monitor checks every strobe
// against that queue in order. A slave model returns random read data and
// records the value each read response must carry.
module tb_ctl_master;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;

`ifdef CTL_MASTER_AUTOBOOT_EN
  localparam logic RST_READY = 1'b0;
  localparam logic RST_BOOT  = 1'b0;
`else
  localparam logic RST_READY = 1'b1;
  localparam logic RST_BOOT  = 1'b1;
`endif

  logic              clk, clrn;
  logic              cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy, boot_done;
  logic              ctl_wr, ctl_rd;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wrdata, ctl_rddata;
  logic [1:0]        fsm_state;

  ctl_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .clrn(clrn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .boot_done(boot_done),
    .ctl_wr(ctl_wr), .ctl_rd(ctl_rd), .ctl_addr(ctl_addr),
    .ctl_wrdata(ctl_wrdata), .ctl_rddata(ctl_rddata),
    .fsm_state(fsm_state)
  );

  // ------------------------------------------------------ clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------ scoreboard state
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  cmd_t              bus_q[$];   // expected bus transactions in order
  logic [DATA_W-1:0] exp_q[$];   // expected read response data
  int                strobe_cyc[$];
  int                compared   = 0;
  int                mismatched = 0;
  int                cyc        = 0;
  int                rsp_count  = 0;
  logic              ready_low_seen;
  logic              slave_fixed_en;
  logic [DATA_W-1:0] slave_fixed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave: read data is valid in the cycle after the ctl_rd cycle. In every
  // other cycle the slave drives random data, so a capture taken on the wrong
  // cycle does not match.
  logic [DATA_W-1:0] slave_v;
  always @(posedge clk) begin
    if (ctl_rd) begin
      slave_v = slave_fixed_en ? slave_fixed : DATA_W'($urandom);
      exp_q.push_back(slave_v);
      ctl_rddata <= slave_v;
    end else begin
      ctl_rddata <= DATA_W'($urandom);
    end
  end

  // Bus and response monitor
  cmd_t mon_e;
  always @(negedge clk) begin
    cyc++;
    if (clrn) begin
      if (ctl_wr || ctl_rd) begin
        strobe_cyc.push_back(cyc);
        if (bus_q.size() == 0) begin
          chk("unexpected_strobe", {ctl_wr, ctl_rd}, 2'b00);
        end else begin
          mon_e = bus_q.pop_front();
          chk("strobe_kind", {ctl_wr, ctl_rd}, mon_e.wr ? 2'b10 : 2'b01);
          chk("strobe_addr", ctl_addr, mon_e.addr);
          if (mon_e.wr) chk("strobe_wrdata", ctl_wrdata, mon_e.data);
        end
      end else begin
        chk("idle_bus", {ctl_addr, ctl_wrdata}, '0);
      end
      if (rsp_valid) begin
        rsp_count++;
        if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, 1'b0);
        else                   chk("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  // ------------------------------------------------------ driver tasks
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push_cmd(input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data);
    int   t = 0;
    cmd_t c;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_data  = data;
    while (!cmd_ready && t < 100) begin
      ready_low_seen = 1'b1;
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      chk("push_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
    end else begin
      c.wr = wr; c.addr = addr; c.data = data;
      bus_q.push_back(c);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || bus_q.size() != 0 || exp_q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_busy", busy, 1'b0);
    chk("drain_pending", bus_q.size() + exp_q.size(), 0);
  endtask

  // Called at the falling edge where clrn is released.
  task automatic do_boot();
`ifdef CTL_MASTER_AUTOBOOT_EN
    logic [ADDR_W-1:0] ba [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd0};
    logic [DATA_W-1:0] bd [6] = '{32'h0A463214, 32'h0A1E281E, 32'h0A1E0A64,
                                  32'h0A3C5032, 32'h0, 32'h1};
    cmd_t c;
    int   t = 0;
    for (int i = 0; i < 6; i++) begin
      c.wr = 1'b1; c.addr = ba[i]; c.data = bd[i];
      bus_q.push_back(c);
    end
    @(negedge clk);
    chk("boot_ready_low", cmd_ready, 1'b0);
    chk("boot_done_low", boot_done, 1'b0);
    while (!boot_done && t < 30) begin @(negedge clk); t++; end
    chk("boot_done", boot_done, 1'b1);
    chk("boot_within_14", t <= 13, 1'b1);
    chk("boot_writes_left", bus_q.size(), 0);
    chk("boot_ready", cmd_ready, 1'b1);
`else
    @(negedge clk);
    chk("noboot_done", boot_done, 1'b1);
    chk("noboot_ready", cmd_ready, 1'b1);
`endif
  endtask

  // ------------------------------------------------------ watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ directed sequence
  int burst_start;
  int rsp_before;
  int t;

  initial begin
    clrn = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0;
    ready_low_seen = 1'b0; slave_fixed_en = 1'b0; slave_fixed = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_cmd_ready", cmd_ready, RST_READY);
    chk("rst_boot_done", boot_done, RST_BOOT);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {ctl_wr, ctl_rd}, 2'b00);
    chk("rst_bus", {ctl_addr, ctl_wrdata}, '0);

    clrn = 1'b1;
    do_boot();
    wait_idle();

    // Single write (addr 1, data 2): strobe for one cycle, 2 cycles after acceptance
    chk("t1_ready", cmd_ready, 1'b1);
    push_cmd(1'b1, 3'd1, 32'd2);            // returns one cycle after E0
    chk("t1_no_strobe_e0", ctl_wr, 1'b0);
    @(negedge clk);
    chk("t1_wr", ctl_wr, 1'b1);
    chk("t1_addr", ctl_addr, 3'd1);
    chk("t1_wrdata", ctl_wrdata, 32'd2);
    @(negedge clk);
    chk("t1_wr_drop", ctl_wr, 1'b0);
    chk("t1_no_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    chk("t1_no_rsp2", rsp_valid, 1'b0);
    wait_idle();

    // Single read of addr 0, slave returns 1
    slave_fixed_en = 1'b1; slave_fixed = 32'h1;
    push_cmd(1'b0, 3'd0, 32'hDEAD);         // after E0
    @(negedge clk);                          // after E1
    chk("t2_rd", ctl_rd, 1'b1);
    chk("t2_addr", ctl_addr, 3'd0);
    @(negedge clk);                          // after E2
    chk("t2_rsp_early", rsp_valid, 1'b0);
    @(negedge clk);                          // after E3
    chk("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_rsp_data", rsp_data, 32'h1);
    @(negedge clk);
    chk("t2_rsp_pulse", rsp_valid, 1'b0);
    chk("t2_rsp_held", rsp_data, 32'h1);
    slave_fixed_en = 1'b0;
    wait_idle();

    // Back-to-back burst: FIFO fills, order kept, strobes exactly 2 cycles apart
    burst_start = strobe_cyc.size();
    ready_low_seen = 1'b0;
    for (int i = 0; i < 8; i++)
      push_cmd(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
    wait_idle();
    chk("burst_ready_low", ready_low_seen, 1'b1);
    chk("burst_count", strobe_cyc.size() - burst_start, 8);
    if (strobe_cyc.size() >= burst_start + 8)
      for (int i = burst_start + 1; i < burst_start + 8; i++)
        chk("burst_spacing", strobe_cyc[i] - strobe_cyc[i-1], 2);

    // Interleaved write / read / write: exactly one response
    rsp_before = rsp_count;
    push_cmd(1'b1, 3'd3, DATA_W'($urandom));
    push_cmd(1'b0, 3'd5, DATA_W'($urandom));
    push_cmd(1'b1, 3'd6, DATA_W'($urandom));
    wait_idle();
    chk("ilv_rsp_count", rsp_count - rsp_before, 1);

    // Reset during ISSUE of a queued batch: no replay afterwards
    for (int i = 0; i < 4; i++)
      push_cmd(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
    t = 0;
    do begin @(negedge clk); t++; end while (!(ctl_wr || ctl_rd) && t < 20);
    chk("abort_saw_issue", ctl_wr || ctl_rd, 1'b1);
    #2 clrn = 1'b0;
    #1;
    chk("abort_strobes", {ctl_wr, ctl_rd}, 2'b00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", cmd_ready, RST_READY);
    bus_q.delete();
    exp_q.delete();
    @(negedge clk);
    clrn = 1'b1;
    do_boot();
    repeat (20) @(negedge clk);
    chk("abort_idle_busy", busy, 1'b0);
    chk("abort_no_replay", bus_q.size(), 0);

    // Randomized traffic with random idle gaps
    rsp_before = rsp_count;
    t = 0;
    for (int i = 0; i < 40; i++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      if (!w) t++;
      push_cmd(w, ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    chk("rand_rsp_count", rsp_count - rsp_before, t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
